// File: rtl/btn_debounce_if.sv
// Button bundle between the raw pins and the debouncer: raw pins in,
// debounced level and press tick out. The board side is the master.
interface btn_debounce_if #(
    parameter int unsigned N_BTN = 2
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] db_level;
    logic [N_BTN-1:0] db_tick;

    modport master (
        output btn_raw,
        input  db_level,
        input  db_tick
    );

    modport slave (
        input  btn_raw,
        output db_level,
        output db_tick
    );
endinterface

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer. Each channel runs a 2-FF synchroniser
// into a four-state dwell FSM and produces a registered level and a one-clock
// press tick. Define BTN_DB_AUTOREPEAT_EN to add periodic ticks while held.
module btn_debounce #(
    parameter int unsigned N_BTN         = 2,
    parameter int unsigned DB_CYCLES     = 1_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic          i_clk,
    input  logic          i_reset,
    btn_debounce_if.slave io_btn
);
    localparam int unsigned   CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_LOAD = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {StZero, StWait1, StOne, StWait0} state_e;

    logic [N_BTN-1:0] r_s1;
    logic [N_BTN-1:0] r_s2;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_tick;
    state_e           r_state [N_BTN];
    logic [CW-1:0]    r_cnt   [N_BTN];

`ifdef BTN_DB_AUTOREPEAT_EN
    localparam int unsigned   RW       = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_LOAD = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0]    r_rcnt  [N_BTN];
`else
    // Keeps the repeat period referenced so both builds share one parameter list.
    logic w_unused_cfg;
    assign w_unused_cfg = ^REPEAT_CYCLES;
`endif

    assign io_btn.db_level = r_level;
    assign io_btn.db_tick  = r_tick;

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= io_btn.btn_raw;
            r_s2 <= r_s1;
        end
    end

    // Per-channel dwell FSM with registered level and tick outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_level <= '0;
            r_tick  <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                r_state[i] <= StZero;
                r_cnt[i]   <= '0;
`ifdef BTN_DB_AUTOREPEAT_EN
                r_rcnt[i]  <= '0;
`endif
            end
        end else begin
            r_tick <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                unique case (r_state[i])
                    StZero: begin
                        if (r_s2[i]) begin
                            r_state[i] <= StWait1;
                            r_cnt[i]   <= DB_LOAD;
                        end
                    end
                    StWait1: begin
                        // Reversal is tested first so a flip on the last dwell cycle rejects.
                        if (!r_s2[i]) begin
                            r_state[i] <= StZero;
                        end else if (r_cnt[i] == '0) begin
                            r_state[i] <= StOne;
                            r_level[i] <= 1'b1;
                            r_tick[i]  <= 1'b1;
`ifdef BTN_DB_AUTOREPEAT_EN
                            r_rcnt[i]  <= RPT_LOAD;
`endif
                        end else begin
                            r_cnt[i] <= r_cnt[i] - 1'b1;
                        end
                    end
                    StOne: begin
                        if (!r_s2[i]) begin
                            r_state[i] <= StWait0;
                            r_cnt[i]   <= DB_LOAD;
                        end
`ifdef BTN_DB_AUTOREPEAT_EN
                        // Repeat timer runs on every cycle spent in StOne.
                        if (r_rcnt[i] == '0) begin
                            r_tick[i] <= 1'b1;
                            r_rcnt[i] <= RPT_LOAD;
                        end else begin
                            r_rcnt[i] <= r_rcnt[i] - 1'b1;
                        end
`endif
                    end
                    StWait0: begin
                        if (r_s2[i]) begin
                            r_state[i] <= StOne;
                        end else if (r_cnt[i] == '0) begin
                            r_state[i] <= StZero;
                            r_level[i] <= 1'b0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] - 1'b1;
                        end
                    end
                    default: r_state[i] <= StZero;
                endcase
            end
        end
    end
endmodule

// File: doc/btn_debounce.md
# btn_debounce

Multi-channel push-button debouncer between the board's raw `btn` pins and the pong top level's `btn[1:0]` input. Each channel synchronises its asynchronous pin into `clk`, filters contact bounce with a four-state FSM and dwell counter, and produces a clean level plus a single-cycle press tick. The graphics animator consumes the level for paddle motion; the tick is available for discrete events such as serve and pause.

## Interface
- `N_BTN`, 2: number of independent channels.
- `DB_CYCLES`, 1_000_000: clocks the synchronised input must stay stable before a state change is accepted (20 ms at 50 MHz). Must be ≥ 2.
- `REPEAT_CYCLES`, 10_000_000: auto-repeat period. Used only when `BTN_DB_AUTOREPEAT_EN` is defined. Must be ≥ 2.
- `clk`  in  1  system clock; also the pixel-clock source domain.
- `reset`  in  1  **synchronous, active-high** reset.
- `btn_raw`  in  `N_BTN`  raw, asynchronous, bouncing button pins; 1 = pressed.
- `db_level`  out  `N_BTN`  debounced level, registered.
- `db_tick`  out  `N_BTN`  one-clock pulse on an accepted press (and on repeats, when enabled), registered.

## Operation
- Per channel: a 2-FF synchroniser (`s1`, `s2`) drives the FSM input `s`. Channels share no state.
- FSM states: `ZERO`, `WAIT1`, `ONE`, `WAIT0`.
- `ZERO`:
  - `s`=1 → `WAIT1`, `cnt` ← `DB_CYCLES-1`.
  - Otherwise stay.
- `WAIT1`:
  - `s`=0 → `ZERO` (bounce rejected; no output change).
  - Else `cnt`=0 → `ONE`; `db_level` ← 1; `db_tick` ← 1.
  - Else `cnt` ← `cnt-1`.
- `ONE`:
  - `s`=0 → `WAIT0`, `cnt` ← `DB_CYCLES-1`.
  - Otherwise stay.
- `WAIT0`:
  - `s`=1 → `ONE` (glitch rejected; `db_level` stays 1; no tick).
  - Else `cnt`=0 → `ZERO`; `db_level` ← 0.
  - Else `cnt` ← `cnt-1`.
- `db_tick` defaults to 0 every cycle it is not explicitly set, so it is exactly one clock wide.
- Widths: `cnt` is `$clog2(DB_CYCLES)` bits and `rcnt` is `$clog2(REPEAT_CYCLES)` bits. Both counters are unsigned, count down, and never wrap. The zero test precedes the decrement.
- Reset (any cycle, including mid-`WAIT*`):
  - `s1`, `s2`, `cnt`, `rcnt` ← 0.
  - State ← `ZERO`; `db_level` ← 0; `db_tick` ← 0.
  - A button still held after reset is re-debounced from scratch; no tick is suppressed or duplicated.

## Timing
- All outputs are registered; there is no combinational path from `btn_raw` to any output.
- Reset values: `db_level` = 0, `db_tick` = 0.
- Press latency: let edge E be the first edge sampling `btn_raw`=1 (held steady). `db_level` and `db_tick` go high at edge E+`DB_CYCLES`+2.
- Release latency: `db_level` falls at edge E'+`DB_CYCLES`+2, where E' is the first edge sampling `btn_raw`=0. There is no tick on release.
- A bounce shorter than `DB_CYCLES` consecutive stable synchronised samples produces no output change.
- A reversal on the final dwell cycle (`cnt`=0 with `s` reverted) takes the reversal branch, not the accept branch.

## Configuration
- `BTN_DB_AUTOREPEAT_EN` defined:
  - Entering `ONE` from `WAIT1` loads `rcnt` ← `REPEAT_CYCLES-1`.
  - While in `ONE` (including the `ONE` → `WAIT0` → `ONE` glitch path, which does not reload `rcnt`):
    - `rcnt`=0 → `db_tick` ← 1 and `rcnt` reloads.
    - Otherwise `rcnt` decrements.
  - `rcnt` holds in `WAIT0` and is ignored in `ZERO` and `WAIT1`.
- Not defined: `rcnt` is absent; `db_tick` fires only on the `WAIT1` → `ONE` transition.

## Test plan
Bench parameters: `DB_CYCLES`=8, `REPEAT_CYCLES`=20, `N_BTN`=2.
- Clean press: `btn_raw[0]` 0 → 1 at edge 10, held → `db_level[0]` = 1 and `db_tick[0]` one-cycle pulse at edge 20; `db_tick[0]` = 0 at edge 21. Channel 1 stays 0.
- Bounce rejection: `btn_raw[0]` toggles every 3 clocks for 40 clocks, then stays 0 → `db_level[0]` and `db_tick[0]` remain 0 throughout.
- Release with glitch: held pressed, release at edge 100 with a 2-clock high blip at edge 103 → `db_level[0]` falls after the dwell restarts on the blip (the blip is rejected); no tick on release.
- Simultaneous channels: both pins rise at edge 10; channel 1 bounces once at edge 14 → channel 0 accepts at edge 20; channel 1 accepts later, at the restarted-dwell time. The two channels are independent.
- Reset mid-dwell: `reset` asserted at edge 15 while channel 0 is in `WAIT1`, button held → outputs are 0 at edge 16; `db_level[0]` rises 10 edges after the first post-reset sample of the held button.
- Auto-repeat (`BTN_DB_AUTOREPEAT_EN`): hold 100 clocks → initial press tick, then ticks every 20 clocks.
  - Without the macro: exactly one tick.
